lmac_rx_pkt_fifo: RTL and testbench

//  Parametrised single-clock, store-and-forward RX packet FIFO between the LMAC receive datapath and EXTR.

---
 rtl/lmac_rx_pkt_fifo.sv | 165 ++++++++++++++++
 tb/tb_lmac_rx_pkt_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lmac_rx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// lmac_rx_pkt_fifo
//
// Single-clock store-and-forward RX packet FIFO between the LMAC receive
// datapath and EXTR. Frames are written speculatively behind a commit pointer
// and only become readable once their EOP is accepted without error. Errored,
// truncated (missing EOP) and overflowing frames are rewound and counted.
//
// Optional feature macro: LMAC_RXF_SHOWAHEAD_EN
//   undefined : rx_mac_data/ctrl update one cycle after an accepted rx_mac_rd
//               and hold until the next accepted read.
//   defined   : a prefetch register presents the head word whenever
//               rx_mac_empty=0; rx_mac_rd consumes it (1 word/cycle).
//
// Ports
//   clk, reset_      core clock, asynchronous active-low reset
//   rx_wr*           write side: strobe, data, sop, eop, err (err with eop)
//   rx_wr_full       no free word (speculative + committed == DEPTH)
//   rx_mac_rd        pop one committed word
//   rx_mac_data/ctrl read data; ctrl = {6'b0, pkt_end, pkt_start}
//   rx_mac_empty     no committed word available
//   rx_mac_usedw     committed words held
//   fifo_ov          one-cycle pulse when a frame is dropped on overflow
//   drop_cnt         saturating count of dropped frames; clr_cnt clears it
// -----------------------------------------------------------------------------
module lmac_rx_pkt_fifo #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              rx_wr,
   input  logic [DATA_W-1:0] rx_wr_data,
   input  logic              rx_wr_sop,
   input  logic              rx_wr_eop,
   input  logic              rx_wr_err,
   output logic              rx_wr_full,
   input  logic              rx_mac_rd,
   output logic [DATA_W-1:0] rx_mac_data,
   output logic [7:0]        rx_mac_ctrl,
   output logic              rx_mac_empty,
   output logic [ADDR_W:0]   rx_mac_usedw,
   output logic              fifo_ov,
   output logic [CNT_W-1:0]  drop_cnt,
   input  logic              clr_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int PW    = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_STORE, S_DISCARD} state_t;

   // Word layout in RAM: {eop, sop, data}
   logic [DATA_W+1:0] r_mem [DEPTH];
   logic [DATA_W+1:0] r_rd_q;

   logic [PW-1:0]     r_wr_ptr, r_cmt_ptr, r_rd_ptr;
   state_t            r_state;
   logic              r_fifo_ov;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic              w_full, w_base_full, w_space_full;
   logic              w_accept, w_we, w_drop, w_load, w_ram_empty;
   logic [PW-1:0]     w_base, w_base_inc;

   // Space checks use the registered rd_ptr, so a same-cycle pop never frees
   // room for that cycle's write.
   assign w_full      = (r_wr_ptr  - r_rd_ptr) == PW'(DEPTH);
   assign w_base_full = (r_cmt_ptr - r_rd_ptr) == PW'(DEPTH);
   assign w_ram_empty = (r_rd_ptr == r_cmt_ptr);

   // Every SOP starts a frame at the commit pointer, which also rewinds a
   // frame still open in STORE (missing EOP). Outside STORE only SOP words
   // are taken; other words are ignored.
   assign w_base       = rx_wr_sop ? r_cmt_ptr : r_wr_ptr;
   assign w_base_inc   = w_base + PW'(1);
   assign w_space_full = rx_wr_sop ? w_base_full : w_full;
   assign w_accept     = rx_wr && (rx_wr_sop || r_state == S_STORE);
   assign w_we         = w_accept && !w_space_full;
   assign w_drop       = w_accept && ((r_state == S_STORE && rx_wr_sop) ||
                                      w_space_full || (rx_wr_eop && rx_wr_err));

   // NOTE: storage array has no reset so it maps onto block RAM; only the
   // pointers and output register are reset.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_base[ADDR_W-1:0]] <= {rx_wr_eop, rx_wr_sop, rx_wr_data};
   end

   // Write-side FSM and pointers
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_cmt_ptr <= '0;
         r_fifo_ov <= 1'b0;
      end else begin
         r_fifo_ov <= w_accept && w_space_full;
         if (w_accept) begin
            if (w_space_full) begin
               r_wr_ptr <= r_cmt_ptr;
               r_state  <= rx_wr_eop ? S_IDLE : S_DISCARD;
            end else if (rx_wr_eop) begin
               r_state <= S_IDLE;
               if (rx_wr_err) begin
                  r_wr_ptr <= r_cmt_ptr;
               end else begin
                  r_wr_ptr  <= w_base_inc;
                  r_cmt_ptr <= w_base_inc;
               end
            end else begin
               r_wr_ptr <= w_base_inc;
               r_state  <= S_STORE;
            end
         end else if (rx_wr && rx_wr_eop && r_state == S_DISCARD) begin
            r_state <= S_IDLE;
         end
      end
   end

   // NOTE: clear has priority over a same-cycle increment; count saturates.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)                          r_drop_cnt <= '0;
      else if (clr_cnt)                     r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + CNT_W'(1);
   end

`ifdef LMAC_RXF_SHOWAHEAD_EN
   logic r_vld;

   // Refill the output stage whenever it is empty or being consumed.
   assign w_load = !w_ram_empty && (!r_vld || rx_mac_rd);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)        r_vld <= 1'b0;
      else if (w_load)    r_vld <= 1'b1;
      else if (rx_mac_rd) r_vld <= 1'b0;
   end

   assign rx_mac_empty = !r_vld;
   assign rx_mac_usedw = (r_cmt_ptr - r_rd_ptr) + PW'(r_vld);
`else
   assign w_load       = rx_mac_rd && !w_ram_empty;
   assign rx_mac_empty = w_ram_empty;
   assign rx_mac_usedw = r_cmt_ptr - r_rd_ptr;
`endif

   // Registered read port
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_rd_ptr <= '0;
         r_rd_q   <= '0;
      end else if (w_load) begin
         r_rd_q   <= r_mem[r_rd_ptr[ADDR_W-1:0]];
         r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   assign rx_mac_data = r_rd_q[DATA_W-1:0];
   assign rx_mac_ctrl = {6'b0, r_rd_q[DATA_W+1], r_rd_q[DATA_W]};
   assign rx_wr_full  = w_full;
   assign fifo_ov     = r_fifo_ov;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_lmac_rx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_lmac_rx_pkt_fifo
//
// Self-checking bench for lmac_rx_pkt_fifo (DATA_W=16, ADDR_W=4, CNT_W=4).
// Committed words are pushed to a scoreboard queue as frames are driven and
// popped/compared as they are read back. A vector table covers good, errored
// and single-word frames; hand-written sequences cover overflow, missing EOP
// and counter saturation/clear. Works with or without LMAC_RXF_SHOWAHEAD_EN.
// -----------------------------------------------------------------------------
module tb_lmac_rx_pkt_fifo;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int CW = 4;
`ifdef LMAC_RXF_SHOWAHEAD_EN
   localparam int OV_IDX = 7;   // prefetched word has left the RAM
`else
   localparam int OV_IDX = 6;
`endif

   logic          clk = 1'b0;
   logic          reset_;
   logic          rx_wr, rx_wr_sop, rx_wr_eop, rx_wr_err;
   logic [DW-1:0] rx_wr_data;
   logic          rx_wr_full;
   logic          rx_mac_rd;
   logic [DW-1:0] rx_mac_data;
   logic [7:0]    rx_mac_ctrl;
   logic          rx_mac_empty;
   logic [AW:0]   rx_mac_usedw;
   logic          fifo_ov;
   logic [CW-1:0] drop_cnt;
   logic          clr_cnt;

   lmac_rx_pkt_fifo #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset_       (reset_),
      .rx_wr        (rx_wr),
      .rx_wr_data   (rx_wr_data),
      .rx_wr_sop    (rx_wr_sop),
      .rx_wr_eop    (rx_wr_eop),
      .rx_wr_err    (rx_wr_err),
      .rx_wr_full   (rx_wr_full),
      .rx_mac_rd    (rx_mac_rd),
      .rx_mac_data  (rx_mac_data),
      .rx_mac_ctrl  (rx_mac_ctrl),
      .rx_mac_empty (rx_mac_empty),
      .rx_mac_usedw (rx_mac_usedw),
      .fifo_ov      (fifo_ov),
      .drop_cnt     (drop_cnt),
      .clr_cnt      (clr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [7:0]    ctrl;
   } sb_t;

   typedef struct {
      int nw;
      bit err;
      int exp_usedw;
      int exp_drop;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[5];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   exp_drop = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_wr();
      rx_wr      = 1'b0;
      rx_wr_sop  = 1'b0;
      rx_wr_eop  = 1'b0;
      rx_wr_err  = 1'b0;
   endtask

   task automatic drive_word(input logic [DW-1:0] d, input bit sop, input bit eop, input bit err);
      rx_wr      = 1'b1;
      rx_wr_data = d;
      rx_wr_sop  = sop;
      rx_wr_eop  = eop;
      rx_wr_err  = err;
      tick();
   endtask

   // Drive an n-word frame; push its words to the scoreboard if it should commit.
   task automatic send_frame(input int id, input int n, input bit err, input bit eop_en, input bit push);
      logic [DW-1:0] d;
      bit sop, eop;
      for (int i = 0; i < n; i++) begin
         d   = DW'(id * 256 + i);
         sop = (i == 0);
         eop = eop_en && (i == n - 1);
         drive_word(d, sop, eop, err && eop);
         if (push) sb_q.push_back('{data: d, ctrl: {6'b0, eop, sop}});
      end
      idle_wr();
   endtask

   // Read n words and compare each against the scoreboard head.
   task automatic drain(input int n, input string tag);
      sb_t e;
      tick();
      for (int i = 0; i < n; i++) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty at word %0d", tag, i);
         end else begin
            e = sb_q.pop_front();
`ifdef LMAC_RXF_SHOWAHEAD_EN
            check({tag, "_empty"}, rx_mac_empty, 0);
            check({tag, "_data"},  rx_mac_data, e.data);
            check({tag, "_ctrl"},  rx_mac_ctrl, e.ctrl);
            rx_mac_rd = 1'b1;
            tick();
`else
            rx_mac_rd = 1'b1;
            tick();
            check({tag, "_data"},  rx_mac_data, e.data);
            check({tag, "_ctrl"},  rx_mac_ctrl, e.ctrl);
`endif
         end
      end
      rx_mac_rd = 1'b0;
   endtask

   initial begin
      vecs = '{'{4, 1'b0, 4, 0}, '{3, 1'b1, 4, 1}, '{1, 1'b0, 5, 1},
               '{1, 1'b1, 5, 2}, '{5, 1'b0, 10, 2}};

      reset_     = 1'b0;
      rx_wr_data = '0;
      rx_mac_rd  = 1'b0;
      clr_cnt    = 1'b0;
      idle_wr();
      repeat (3) tick();
      check("rst_empty", rx_mac_empty, 1);
      check("rst_usedw", rx_mac_usedw, 0);
      check("rst_full",  rx_wr_full, 0);
      check("rst_ov",    fifo_ov, 0);
      check("rst_drop",  drop_cnt, 0);
      check("rst_data",  rx_mac_data, 0);
      check("rst_ctrl",  rx_mac_ctrl, 0);
      reset_ = 1'b1;
      tick();

      // T1: 4-word good frame, commit visibility and drain
      send_frame(1, 4, 1'b0, 1'b1, 1'b1);
`ifdef LMAC_RXF_SHOWAHEAD_EN
      check("t1_empty_eop", rx_mac_empty, 1);
      tick();
      check("t1_empty_next", rx_mac_empty, 0);
`else
      check("t1_empty_eop", rx_mac_empty, 0);
`endif
      check("t1_usedw", rx_mac_usedw, 4);
      drain(4, "t1");
      check("t1_empty_end", rx_mac_empty, 1);
      check("t1_usedw_end", rx_mac_usedw, 0);
      rx_mac_rd = 1'b1;
      tick();
      rx_mac_rd = 1'b0;
      check("rd_empty_usedw", rx_mac_usedw, 0);
      check("rd_empty_data",  rx_mac_data, 16'h0103);
      check("rd_empty_ctrl",  rx_mac_ctrl, 8'h02);

      // Vector table: good / errored / single-word frames
      for (int k = 0; k < 5; k++) begin
         send_frame(10 + k, vecs[k].nw, vecs[k].err, 1'b1, !vecs[k].err);
         tick();
         check("vec_usedw", rx_mac_usedw, vecs[k].exp_usedw);
         check("vec_drop",  drop_cnt, vecs[k].exp_drop);
         check("vec_ov",    fifo_ov, 0);
         check("vec_empty", rx_mac_empty, 0);
      end
      exp_drop = 2;
      drain(10, "vec");
      check("vec_empty_end", rx_mac_empty, 1);
      check("vec_usedw_end", rx_mac_usedw, 0);

      // T3: 10-word frame commits, 8-word frame overflows
      send_frame(20, 10, 1'b0, 1'b1, 1'b1);
      tick();
      check("t3_usedw_a", rx_mac_usedw, 10);
      for (int i = 0; i < 8; i++) begin
         if (i == OV_IDX) check("t3_full", rx_wr_full, 1);
         drive_word(DW'(21 * 256 + i), i == 0, i == 7, 1'b0);
         if (i == OV_IDX) check("t3_ov_pulse", fifo_ov, 1);
         if (i == OV_IDX + 1) check("t3_ov_end", fifo_ov, 0);
      end
      idle_wr();
      exp_drop++;
      tick();
      check("t3_ov_idle", fifo_ov, 0);
      check("t3_usedw_b", rx_mac_usedw, 10);
      check("t3_drop",    drop_cnt, exp_drop);
      check("t3_notfull", rx_wr_full, 0);
      drain(10, "t3");

      // T4: SOP mid-frame drops the open frame; second frame commits intact
      send_frame(30, 3, 1'b0, 1'b0, 1'b0);
      send_frame(31, 4, 1'b0, 1'b1, 1'b1);
      exp_drop++;
      tick();
      check("t4_drop",  drop_cnt, exp_drop);
      check("t4_usedw", rx_mac_usedw, 4);
      drain(4, "t4");

      // T5: saturation, then clear beating a same-cycle increment
      while (exp_drop < 15) begin
         send_frame(40, 1, 1'b1, 1'b1, 1'b0);
         exp_drop++;
      end
      tick();
      check("t5_at_max", drop_cnt, 15);
      send_frame(41, 1, 1'b1, 1'b1, 1'b0);
      send_frame(42, 2, 1'b1, 1'b1, 1'b0);
      tick();
      check("t5_sat", drop_cnt, 15);
      clr_cnt = 1'b1;
      drive_word(16'h2B00, 1'b1, 1'b1, 1'b1);
      clr_cnt = 1'b0;
      idle_wr();
      tick();
      check("t5_clr_wins", drop_cnt, 0);
      send_frame(44, 1, 1'b1, 1'b1, 1'b0);
      tick();
      check("t5_inc", drop_cnt, 1);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("t5_clr", drop_cnt, 0);
      check("t5_usedw", rx_mac_usedw, 0);
      check("t5_empty", rx_mac_empty, 1);

      check("sb_left", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
